// File: rtl/uart_rx_pkg.sv
// rtl/uart_rx_pkg.sv - shared types and constants for the UART receive core
package uart_rx_pkg;

    localparam int CLKS_PER_BIT_DEF = 10;
    localparam int DATA_BITS_DEF    = 8;

    // Bit index must be able to hold 0..DATA_BITS.
    function automatic int idx_width(input int data_bits);
        return $clog2(data_bits + 1);
    endfunction

    localparam int BIT_IDX_W = idx_width(DATA_BITS_DEF);

    typedef enum logic [2:0] {
        IDLE,
        START_CHK,
        DATA,
        STOP,
        LOAD
    } state_t;

endpackage

// File: rtl/uart_bit_timer.sv
// rtl/uart_bit_timer.sv - bit-period down-counter with one-cycle expire pulse
//   clk, n_rst  : clock, asynchronous active-low reset
//   load        : reload the counter with load_value and arm it
//   load_value  : cycles remaining minus one until expire
//   expire      : high for one cycle when an armed count reaches zero
module uart_bit_timer #(
    parameter int CLKS_PER_BIT = 10
) (
    input  logic                            clk,
    input  logic                            n_rst,
    input  logic                            load,
    input  logic [$clog2(CLKS_PER_BIT)-1:0] load_value,
    output logic                            expire
);

    localparam int W = $clog2(CLKS_PER_BIT);

    logic [W-1:0] count;
    logic         armed;

    // Counter parks at zero after expiring; it only runs again after a reload.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            count <= '0;
            armed <= 1'b0;
        end else if (load) begin
            count <= load_value;
            armed <= 1'b1;
        end else if (armed) begin
            if (count == '0) begin
                armed <= 1'b0;
            end else begin
                count <= count - W'(1);
            end
        end
    end

    assign expire = armed && (count == '0);

endmodule

// File: rtl/uart_rx_core.sv
// rtl/uart_rx_core.sv - UART receiver: start detect, mid-bit sampling, stop check
//   clk, n_rst     : clock, asynchronous active-low reset
//   serial_in      : synchronized serial line, idle high
//   data_read      : one-cycle pulse consuming the current byte
//   rx_data        : last good received byte
//   data_ready     : rx_data holds an unread byte
//   overrun_error  : a new byte overwrote an unread byte
//   framing_error  : last frame had a zero stop bit
module uart_rx_core
    import uart_rx_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
    parameter int DATA_BITS    = DATA_BITS_DEF
) (
    input  logic                 clk,
    input  logic                 n_rst,
    input  logic                 serial_in,
    input  logic                 data_read,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 data_ready,
    output logic                 overrun_error,
    output logic                 framing_error
);

    localparam int TW = $clog2(CLKS_PER_BIT);
    localparam int IW = idx_width(DATA_BITS);
    localparam logic [TW-1:0] HALF_LOAD = TW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [TW-1:0] FULL_LOAD = TW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] LAST_IDX  = IW'(DATA_BITS - 1);

    state_t               state;
    state_t               state_next;
    logic                 prev;
    logic [DATA_BITS-1:0] shift_reg;
    logic [IW-1:0]        bit_idx;

    logic                 timer_load;
    logic [TW-1:0]        timer_value;
    logic                 expire;

    logic                 start_edge;
    logic                 shift_en;
    logic                 idx_clr;
    logic                 fe_set;
    logic                 fe_clr;
    logic                 load_byte;

    uart_bit_timer #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_bit_timer (
        .clk        (clk),
        .n_rst      (n_rst),
        .load       (timer_load),
        .load_value (timer_value),
        .expire     (expire)
    );

    // prev tracks the line in every state so a start bit right after
    // STOP/LOAD is still seen as a falling edge.
    assign start_edge = (state == IDLE) && !serial_in && prev;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        timer_load  = 1'b0;
        timer_value = FULL_LOAD;
        shift_en    = 1'b0;
        idx_clr     = 1'b0;
        fe_set      = 1'b0;
        fe_clr      = 1'b0;
        load_byte   = 1'b0;
        case (state)
            IDLE: begin
                if (start_edge) begin
                    state_next  = START_CHK;
                    timer_load  = 1'b1;
                    timer_value = HALF_LOAD;
                    fe_clr      = 1'b1;
                end
            end
            START_CHK: begin
                if (expire) begin
                    if (!serial_in) begin
                        state_next = DATA;
                        timer_load = 1'b1;
                        idx_clr    = 1'b1;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            DATA: begin
                if (expire) begin
                    shift_en   = 1'b1;
                    timer_load = 1'b1;
                    if (bit_idx == LAST_IDX) begin
                        state_next = STOP;
                    end
                end
            end
            STOP: begin
                if (expire) begin
                    if (serial_in) begin
                        state_next = LOAD;
                    end else begin
                        fe_set     = 1'b1;
                        state_next = IDLE;
                    end
                end
            end
            LOAD: begin
                load_byte  = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            prev          <= 1'b1;
            shift_reg     <= '0;
            bit_idx       <= '0;
            rx_data       <= '0;
            data_ready    <= 1'b0;
            overrun_error <= 1'b0;
            framing_error <= 1'b0;
        end else begin
            prev <= serial_in;

            // LSB arrives first, so bits enter at the MSB and walk down.
            if (shift_en) begin
                shift_reg <= {serial_in, shift_reg[DATA_BITS-1:1]};
            end

            if (idx_clr) begin
                bit_idx <= '0;
            end else if (shift_en) begin
                bit_idx <= bit_idx + IW'(1);
            end

            if (fe_clr) begin
                framing_error <= 1'b0;
            end else if (fe_set) begin
                framing_error <= 1'b1;
            end

            // A read coinciding with the load acknowledges the old byte,
            // so the new one is kept without flagging an overrun.
            if (load_byte) begin
                rx_data    <= shift_reg;
                data_ready <= 1'b1;
                if (data_read) begin
                    overrun_error <= 1'b0;
                end else if (data_ready) begin
                    overrun_error <= 1'b1;
                end
            end else if (data_read) begin
                data_ready    <= 1'b0;
                overrun_error <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_core.sv
// tb/tb_uart_rx_core.sv - self-checking bench for uart_rx_core
module tb_uart_rx_core;

    localparam int CPB          = 10;
    localparam int NB           = 8;
    localparam int FRAME_CYCLES = CPB * (NB + 2);
    localparam int STOP_K       = CPB / 2 + CPB * (NB + 1);
    localparam int LOAD_K       = STOP_K + 1;

    logic          clk = 1'b0;
    logic          n_rst;
    logic          serial_in;
    logic          data_read;
    logic [NB-1:0] rx_data;
    logic          data_ready;
    logic          overrun_error;
    logic          framing_error;

    int vectors     = 0;
    int miscompares = 0;

    // Reference view of the reader-visible outputs.
    logic [NB-1:0] m_rx;
    logic          m_rdy;
    logic          m_ovr;
    logic          m_fe;

    typedef struct {
        logic [7:0] data;
        logic       stop;
        int         read_k;
        logic       read_after;
        logic [7:0] exp_rx;
        logic       exp_rdy;
        logic       exp_ovr;
        logic       exp_fe;
    } vec_t;

    vec_t tbl[$];

    uart_rx_core #(
        .CLKS_PER_BIT (CPB),
        .DATA_BITS    (NB)
    ) dut (
        .clk           (clk),
        .n_rst         (n_rst),
        .serial_in     (serial_in),
        .data_read     (data_read),
        .rx_data       (rx_data),
        .data_ready    (data_ready),
        .overrun_error (overrun_error),
        .framing_error (framing_error)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_model(input string tag);
        check($sformatf("%s rx_data", tag), 32'(rx_data), 32'(m_rx));
        check($sformatf("%s data_ready", tag), 32'(data_ready), 32'(m_rdy));
        check($sformatf("%s overrun_error", tag), 32'(overrun_error), 32'(m_ovr));
        check($sformatf("%s framing_error", tag), 32'(framing_error), 32'(m_fe));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        serial_in = 1'b1;
        data_read = 1'b0;
        repeat (n) tick();
    endtask

    task automatic pulse_read(input string tag);
        data_read = 1'b1;
        tick();
        data_read = 1'b0;
        if (m_rdy) begin
            m_rdy = 1'b0;
            m_ovr = 1'b0;
        end
        check_model(tag);
    endtask

    // Drives one frame; iteration k ends just after edge E+k, where E is the
    // edge that first sees the start bit. read_k < 0 means no read pulse.
    task automatic send_frame(input logic [NB-1:0] data, input logic stop,
                              input int read_k, input string tag);
        logic [NB+1:0] bits;
        bits = {stop, data, 1'b0};
        for (int k = 0; k < FRAME_CYCLES; k++) begin
            serial_in = bits[k / CPB];
            data_read = (k == read_k);
            tick();
            if (k == 0) m_fe = 1'b0;
            if (k == read_k && !(k == LOAD_K && stop) && m_rdy) begin
                m_rdy = 1'b0;
                m_ovr = 1'b0;
            end
            if (k == STOP_K && !stop) m_fe = 1'b1;
            if (k == LOAD_K && stop) begin
                if (k == read_k) m_ovr = 1'b0;
                else if (m_rdy) m_ovr = 1'b1;
                m_rx  = data;
                m_rdy = 1'b1;
            end
            if (k == 0 || k == STOP_K || k == LOAD_K || k == read_k)
                check_model($sformatf("%s k=%0d", tag, k));
        end
        data_read = 1'b0;
        serial_in = 1'b1;
    endtask

    initial begin
        logic       prev_stop;
        logic [NB+1:0] bits;
        logic [7:0] rd;
        logic       rs;
        int         rk;
        int         sel;

        n_rst     = 1'b0;
        serial_in = 1'b1;
        data_read = 1'b0;
        m_rx = '0; m_rdy = 1'b0; m_ovr = 1'b0; m_fe = 1'b0;
        repeat (3) tick();
        check_model("in_reset");
        n_rst = 1'b1;
        repeat (200) tick();
        check_model("idle_200");

        // Three-cycle glitch: rejected at the half-bit check.
        serial_in = 1'b0;
        repeat (3) tick();
        serial_in = 1'b1;
        repeat (20) tick();
        m_fe = 1'b0;
        check_model("glitch");

        tbl.push_back('{8'hA5, 1'b1, -1, 1'b1, 8'hA5, 1'b1, 1'b0, 1'b0});
        tbl.push_back('{8'h3C, 1'b1, -1, 1'b1, 8'h3C, 1'b1, 1'b0, 1'b0});
        tbl.push_back('{8'h55, 1'b0, -1, 1'b0, 8'h3C, 1'b0, 1'b0, 1'b1});
        tbl.push_back('{8'h0F, 1'b1, -1, 1'b1, 8'h0F, 1'b1, 1'b0, 1'b0});
        tbl.push_back('{8'h12, 1'b1, -1, 1'b0, 8'h12, 1'b1, 1'b0, 1'b0});
        tbl.push_back('{8'h34, 1'b1, -1, 1'b1, 8'h34, 1'b1, 1'b1, 1'b0});
        tbl.push_back('{8'h99, 1'b1, -1, 1'b0, 8'h99, 1'b1, 1'b0, 1'b0});
        tbl.push_back('{8'h81, 1'b1, LOAD_K, 1'b1, 8'h81, 1'b1, 1'b0, 1'b0});

        foreach (tbl[i]) begin
            send_frame(tbl[i].data, tbl[i].stop, tbl[i].read_k, $sformatf("tbl%0d", i));
            check($sformatf("tbl%0d exp rx_data", i), 32'(rx_data), 32'(tbl[i].exp_rx));
            check($sformatf("tbl%0d exp data_ready", i), 32'(data_ready), 32'(tbl[i].exp_rdy));
            check($sformatf("tbl%0d exp overrun", i), 32'(overrun_error), 32'(tbl[i].exp_ovr));
            check($sformatf("tbl%0d exp framing", i), 32'(framing_error), 32'(tbl[i].exp_fe));
            idle(2);
            if (tbl[i].read_after) begin
                pulse_read($sformatf("tbl%0d read", i));
                check($sformatf("tbl%0d ready cleared", i), 32'(data_ready), 32'(0));
            end
        end

        prev_stop = 1'b1;
        for (int n = 0; n < 24; n++) begin
            rd  = 8'($urandom);
            rs  = ($urandom_range(0, 5) != 0);
            sel = $urandom_range(0, 3);
            rk  = (sel == 1) ? $urandom_range(1, 90) : (sel == 2) ? LOAD_K : -1;
            send_frame(rd, rs, rk, $sformatf("rnd%0d", n));
            idle(prev_stop && rs ? $urandom_range(0, 3) : $urandom_range(1, 3));
            if ($urandom_range(0, 2) == 0) pulse_read($sformatf("rnd%0d read", n));
            prev_stop = rs;
        end
        idle(2);

        // Reset in the middle of a frame, with an unread byte pending.
        send_frame(8'h6E, 1'b1, -1, "pre_reset");
        idle(3);
        bits = {1'b1, 8'h5A, 1'b0};
        for (int k = 0; k <= 45; k++) begin
            serial_in = bits[k / CPB];
            tick();
        end
        n_rst = 1'b0;
        #1;
        m_rx = '0; m_rdy = 1'b0; m_ovr = 1'b0; m_fe = 1'b0;
        check_model("mid_reset");
        @(negedge clk);
        serial_in = 1'b1;
        n_rst     = 1'b1;
        idle(20);
        check_model("after_reset");
        send_frame(8'hC3, 1'b1, -1, "recover");
        idle(2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
